// File: rtl/round_sequencer.sv
// Game-round controller: serve/play/loss sequencing, life counting and
// result flags. All outputs are registered from the next-state decode so they
// line up with the state register.
// Optional feature: define ROUND_SEQUENCER_AUTO_SERVE_EN to auto-launch after
// SERVE_TIMEOUT frame ticks spent waiting in SERVE.
module round_sequencer #(
   parameter int unsigned LIVES         = 3,
   parameter int unsigned LOST_DELAY    = 60,
   parameter int unsigned SERVE_TIMEOUT = 180
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       frame_tick,
   input  logic       ball_lost,
   input  logic       bricks_clear,
   output logic [2:0] state,
   output logic       ball_park,
   output logic       move_en,
   output logic       launch,
   output logic [3:0] lives,
   output logic       game_over,
   output logic       game_win
);

   localparam int unsigned CntMax = (LOST_DELAY > SERVE_TIMEOUT) ? LOST_DELAY : SERVE_TIMEOUT;
   localparam int unsigned CntW   = $clog2(CntMax) + 1;

   localparam logic [CntW-1:0] LostLast  = CntW'(LOST_DELAY - 1);
   localparam logic [CntW-1:0] CntSat    = {CntW{1'b1}};
   localparam logic [3:0]      LivesInit = 4'(LIVES);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StLost  = 3'd3,
      StOver  = 3'd4,
      StWin   = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      lives_q, lives_d;
   logic            start_q;
   logic            start_edge;
   logic            ball_park_q, ball_park_d;
   logic            move_en_q, move_en_d;
   logic            launch_q, launch_d;
   logic            game_over_q, game_over_d;
   logic            game_win_q, game_win_d;

   // start_q resets high so a button held through reset gives no edge
   assign start_edge = start & ~start_q;

`ifdef ROUND_SEQUENCER_AUTO_SERVE_EN
   localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_TIMEOUT - 1);
   logic serve_timeout;
   assign serve_timeout = frame_tick && (cnt_q == ServeLast);
`endif

   // Next-state, counter and lives decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lives_d = lives_q;
      unique case (state_q)
         StIdle: begin
            if (start_edge) begin
               state_d = StServe;
               lives_d = LivesInit;
            end
         end
         StServe: begin
`ifdef ROUND_SEQUENCER_AUTO_SERVE_EN
            // A coincident start edge and timeout still yield one transition
            if (start_edge || serve_timeout) begin
               state_d = StPlay;
            end else if (frame_tick && (cnt_q != CntSat)) begin
               cnt_d = cnt_q + CntW'(1);
            end
`else
            if (start_edge) begin
               state_d = StPlay;
            end
`endif
         end
         StPlay: begin
            if (bricks_clear) begin
               state_d = StWin;
            end else if (ball_lost) begin
               state_d = StLost;
               lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
            end
         end
         StLost: begin
            if (frame_tick) begin
               if (cnt_q == LostLast) begin
                  state_d = (lives_q == 4'd0) ? StOver : StServe;
               end else if (cnt_q != CntSat) begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StOver, StWin: begin
            // Back to IDLE only; a second press is needed to serve
            if (start_edge) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Every state is entered with a cleared delay counter
      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   // Output decode from the next state so registered outputs track state_q
   always_comb begin
      ball_park_d = 1'b0;
      move_en_d   = 1'b0;
      game_over_d = 1'b0;
      game_win_d  = 1'b0;
      launch_d    = (state_q == StServe) && (state_d == StPlay);
      unique case (state_d)
         StIdle, StServe, StLost: ball_park_d = 1'b1;
         StPlay:                  move_en_d   = 1'b1;
         StOver:                  game_over_d = 1'b1;
         StWin:                   game_win_d  = 1'b1;
         default:                 ball_park_d = 1'b1;
      endcase
   end

   // State, counter, lives and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         lives_q     <= LivesInit;
         start_q     <= 1'b1;
         ball_park_q <= 1'b1;
         move_en_q   <= 1'b0;
         launch_q    <= 1'b0;
         game_over_q <= 1'b0;
         game_win_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lives_q     <= lives_d;
         start_q     <= start;
         ball_park_q <= ball_park_d;
         move_en_q   <= move_en_d;
         launch_q    <= launch_d;
         game_over_q <= game_over_d;
         game_win_q  <= game_win_d;
      end
   end

   assign state     = state_q;
   assign ball_park = ball_park_q;
   assign move_en   = move_en_q;
   assign launch    = launch_q;
   assign lives     = lives_q;
   assign game_over = game_over_q;
   assign game_win  = game_win_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with LIVES=3, LOST_DELAY=4, SERVE_TIMEOUT=8.
module tb_round_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       frame_tick;
   logic       ball_lost;
   logic       bricks_clear;
   logic [2:0] state;
   logic       ball_park;
   logic       move_en;
   logic       launch;
   logic [3:0] lives;
   logic       game_over;
   logic       game_win;

   int n_checks = 0;
   int n_fails  = 0;
   int n_launch = 0;

   round_sequencer #(
      .LIVES        (3),
      .LOST_DELAY   (4),
      .SERVE_TIMEOUT(8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .frame_tick  (frame_tick),
      .ball_lost   (ball_lost),
      .bricks_clear(bricks_clear),
      .state       (state),
      .ball_park   (ball_park),
      .move_en     (move_en),
      .launch      (launch),
      .lives       (lives),
      .game_over   (game_over),
      .game_win    (game_win)
   );

   always #5 clock = ~clock;

   // Advance one edge and settle; outputs are sampled 1ns after posedge
   task automatic step();
      @(posedge clock);
      #1;
      if (launch === 1'b1) n_launch++;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Release then press; returns right after the edge is taken
   task automatic press();
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic lose();
      ball_lost = 1'b1;
      step();
      ball_lost = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b1;
      frame_tick   = 1'b0;
      ball_lost    = 1'b0;
      bricks_clear = 1'b0;
      repeat (3) step();
      check("rst_state", 8'(state), 8'd0);
      check("rst_lives", 8'(lives), 8'd3);
      check("rst_park", 8'(ball_park), 8'd1);
      check("rst_move", 8'(move_en), 8'd0);
      check("rst_launch", 8'(launch), 8'd0);
      check("rst_over", 8'(game_over), 8'd0);
      check("rst_win", 8'(game_win), 8'd0);

      // Start held through reset release: no edge
      reset = 1'b0;
      repeat (3) step();
      check("held_idle", 8'(state), 8'd0);

      press();
      check("serve_state", 8'(state), 8'd1);
      check("serve_lives", 8'(lives), 8'd3);
      check("serve_park", 8'(ball_park), 8'd1);
      check("serve_move", 8'(move_en), 8'd0);

      n_launch = 0;
      press();
      check("play_state", 8'(state), 8'd2);
      check("play_move", 8'(move_en), 8'd1);
      check("play_launch", 8'(launch), 8'd1);
      check("play_park", 8'(ball_park), 8'd0);
      step();
      check("launch_once", 8'(launch), 8'd0);
      check("launch_cnt", 8'(n_launch), 8'd1);

      // Loss 1: ball_lost held 10 cycles, single decrement
      ball_lost = 1'b1;
      step();
      check("lost1_state", 8'(state), 8'd3);
      check("lost1_lives", 8'(lives), 8'd2);
      repeat (9) step();
      ball_lost = 1'b0;
      check("lost1_held_lives", 8'(lives), 8'd2);
      ticks(3);
      check("lost1_3ticks", 8'(state), 8'd3);
      ticks(1);
      check("lost1_4ticks", 8'(state), 8'd1);
      check("lost1_park", 8'(ball_park), 8'd1);

      // Loss 2 and 3 lead to game over
      press();
      lose();
      ticks(4);
      check("lost2_state", 8'(state), 8'd1);
      check("lost2_lives", 8'(lives), 8'd1);
      press();
      lose();
      check("lost3_lives", 8'(lives), 8'd0);
      ticks(3);
      check("lost3_3ticks", 8'(state), 8'd3);
      ticks(1);
      check("over_state", 8'(state), 8'd4);
      check("over_flag", 8'(game_over), 8'd1);
      check("over_lives", 8'(lives), 8'd0);

      // Held start after OVER->IDLE does not skip to SERVE
      start = 1'b0;
      step();
      start = 1'b1;
      repeat (3) step();
      check("over_to_idle", 8'(state), 8'd0);
      check("over_flag_clr", 8'(game_over), 8'd0);
      press();
      check("restart_state", 8'(state), 8'd1);
      check("restart_lives", 8'(lives), 8'd3);

      // Simultaneous ball_lost and bricks_clear: win has priority
      press();
      ball_lost    = 1'b1;
      bricks_clear = 1'b1;
      step();
      ball_lost    = 1'b0;
      bricks_clear = 1'b0;
      check("win_state", 8'(state), 8'd5);
      check("win_flag", 8'(game_win), 8'd1);
      check("win_lives", 8'(lives), 8'd3);
      press();
      check("win_to_idle", 8'(state), 8'd0);
      press();
      check("win_serve", 8'(state), 8'd1);

      // SERVE with frame ticks and no start
      step();
      n_launch = 0;
      ticks(7);
      check("auto_7ticks", 8'(state), 8'd1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
`ifdef ROUND_SEQUENCER_AUTO_SERVE_EN
      check("auto_state", 8'(state), 8'd2);
      check("auto_launch", 8'(launch), 8'd1);
`else
      check("auto_state", 8'(state), 8'd1);
      check("auto_launch", 8'(launch), 8'd0);
`endif
      repeat (4) step();
`ifdef ROUND_SEQUENCER_AUTO_SERVE_EN
      check("auto_launch_cnt", 8'(n_launch), 8'd1);
`else
      check("auto_launch_cnt", 8'(n_launch), 8'd0);
      press();
`endif
      check("pre_rst_play", 8'(state), 8'd2);

      // Reach LOST with one life left, then reset mid-delay
      lose();
      ticks(4);
      press();
      lose();
      check("lost_l1_lives", 8'(lives), 8'd1);
      ticks(2);
      check("lost_l1_state", 8'(state), 8'd3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_state", 8'(state), 8'd0);
      check("mid_rst_lives", 8'(lives), 8'd3);
      check("mid_rst_cnt", 8'(dut.cnt_q), 8'd0);
      check("mid_rst_park", 8'(ball_park), 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
